// File: rtl/mdio_master.sv
// Clause-22 MDIO master: turns one register-access command into a 64-bit
// MDC/MDIO frame and returns read data (or a no-PHY error) at frame end.
// The pad's open-drain buffer lives outside; this block only supplies the
// drive value, the output enable and consumes the raw pad input.
module mdio_master #(
  parameter int CLK_DIV = 21
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_error,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int PW = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] phase;      // cycle within the current MDC half-period
  logic          mdc_high;   // which half of the bit period the counters are in
  logic [5:0]    bit_cnt;    // frame bit index, MSB of the frame first
  logic [63:0]   shreg;      // outgoing frame, bit 0 of the frame in [63]
  logic          is_read;
  logic [14:0]   rd_shift;   // read data bits 48..62; bit 63 arrives in DONE
  logic          ta_bit;     // sampled second turnaround bit
  logic          mdio_meta;
  logic          mdio_sync;

  // Two-flop synchroniser for the asynchronous pad input.
  always_ff @(posedge clk_i) begin
    // NOTE: reset is synchronous -- it lives inside the clocked block, never in
    // the sensitivity list. Idle bus level is 1 (pulled up), so reset to 1.
    if (!rst_n_i) begin
      mdio_meta <= 1'b1;
      mdio_sync <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments, so mdio_sync takes the old mdio_meta
      // and the two flops form a real two-stage chain.
      mdio_meta <= mdio_i;
      mdio_sync <= mdio_meta;
    end
  end

  // Frame FSM: counters run one cycle ahead of the registered pin outputs, so
  // the pins follow the counter position processed on the previous edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      phase     <= '0;
      mdc_high  <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '1;
      is_read   <= 1'b0;
      rd_shift  <= '0;
      ta_bit    <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          mdc     <= 1'b0;
          mdio_o  <= 1'b1;
          mdio_oe <= 1'b0;
          if (cmd_ready && cmd_valid) begin
            // Read frames carry 1s in TA/DATA so the idle drive value is high.
            shreg <= {32'hFFFF_FFFF, 2'b01, (cmd_write ? 2'b01 : 2'b10),
                      cmd_phy_addr, cmd_reg_addr,
                      (cmd_write ? {2'b10, cmd_data} : 18'h3_FFFF)};
            is_read   <= !cmd_write;
            phase     <= '0;
            mdc_high  <= 1'b0;
            bit_cnt   <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_SHIFT;
          end else begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        ST_SHIFT: begin
          mdc <= mdc_high;
          // First cycle of a low phase: present the next bit, and take the
          // sample of the previous bit, whose high phase just ended.
          if (!mdc_high && phase == '0) begin
            mdio_o  <= shreg[63];
            shreg   <= {shreg[62:0], 1'b1};
            mdio_oe <= !is_read || (bit_cnt < 6'd46);
            if (bit_cnt == 6'd48) begin
              ta_bit <= mdio_sync;
            end else if (bit_cnt > 6'd48) begin
              rd_shift <= {rd_shift[13:0], mdio_sync};
            end
          end
          if (phase == PH_LAST) begin
            phase <= '0;
            if (mdc_high) begin
              mdc_high <= 1'b0;
              bit_cnt  <= bit_cnt + 6'd1;
              if (bit_cnt == 6'd63) begin
                state <= ST_DONE;
              end
            end else begin
              mdc_high <= 1'b1;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end

        ST_DONE: begin
          // This edge ends bit 63's high phase, so its sample is taken here.
          mdc       <= 1'b0;
          mdio_o    <= 1'b1;
          mdio_oe   <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_data  <= is_read ? {rd_shift, mdio_sync} : 16'h0000;
          rsp_error <= is_read & ta_bit;
          state     <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: directed and random commands, a PHY model on the pins,
// and a scoreboard comparing each response and captured frame to a reference.
module tb_mdio_master;

  localparam int D   = 2;
  localparam int LAT = 128 * D + 1;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [4:0]  cmd_phy_addr = '0;
  logic [4:0]  cmd_reg_addr = '0;
  logic [15:0] cmd_data = '0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_error;
  logic        busy;
  logic        mdc;
  logic        mdio_o;
  logic        mdio_oe;
  logic        mdio_i = 1'b1;

  always #5 clk_i = ~clk_i;

  mdio_master #(.CLK_DIV(D)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .busy(busy), .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  typedef struct {
    logic [63:0] frame;   // expected drive values, frame bit 0 at [63]
    logic [63:0] oe;      // expected output enable per frame bit
    logic [15:0] data;
    logic        err;
    longint      acc;     // accept edge number
    logic        present; // PHY answers this read
    logic [15:0] val;     // value the PHY returns
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference: frame content and response straight from the frame layout.
  function automatic exp_t model(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                                 input logic [15:0] d, input logic present,
                                 input logic [15:0] val);
    exp_t e;
    e.frame   = {32'hFFFF_FFFF, 2'b01, (w ? 2'b01 : 2'b10), pa, ra,
                 (w ? 2'b10 : 2'b11), (w ? d : 16'hFFFF)};
    e.oe      = w ? {64{1'b1}} : {{46{1'b1}}, 18'h0};
    e.data    = w ? 16'h0000 : (present ? val : 16'hFFFF);
    e.err     = !w && !present;
    e.acc     = 0;
    e.present = present;
    e.val     = val;
    return e;
  endfunction

  // Pin monitor and PHY model state.
  logic        mdc_prev = 1'b0;
  logic        mdio_o_prev = 1'b1;
  logic        mdio_oe_prev = 1'b0;
  int          rise_cnt = 0;
  logic [63:0] cap_bits = '0;
  logic [63:0] cap_oe = '0;
  longint      t_rise = 0;
  int          timing_err = 0;
  int          change_err = 0;
  int          hold_err = 0;
  logic [15:0] last_data = '0;
  logic        last_err = 1'b0;
  longint      last_rsp_cyc = 0;

  // PHY drive for the bit starting now (k bits already clocked by MDC).
  function automatic logic phy_bit(input int k);
    logic [15:0] v;
    if (k < 47 || k > 63 || sb_q.size() == 0) return 1'b1;
    if (!(cap_bits[29] == 1'b1 && cap_bits[28] == 1'b0)) return 1'b1;  // not a read
    if (!sb_q[0].present) return 1'b1;
    if (k == 47) return 1'b0;
    v = sb_q[0].val;
    return v[63 - k];
  endfunction

  // Monitor: samples pins mid-cycle, plays the PHY, pops the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      rise_cnt  = 0;
      mdio_i    = 1'b1;
      last_data = '0;
      last_err  = 1'b0;
    end else begin
      if ((mdio_o !== mdio_o_prev || mdio_oe !== mdio_oe_prev) &&
          (mdc || (!mdc_prev && rise_cnt != 0)))
        change_err++;
      if (mdc && !mdc_prev) begin
        if (rise_cnt > 0 && cyc - t_rise != 2 * D) timing_err++;
        t_rise = cyc;
        if (rise_cnt < 64) begin
          cap_bits[63 - rise_cnt] = mdio_o;
          cap_oe[63 - rise_cnt]   = mdio_oe;
        end
        rise_cnt++;
      end
      if (!mdc && mdc_prev) begin
        if (cyc - t_rise != D) timing_err++;
        mdio_i = phy_bit(rise_cnt);
      end
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 with nothing pending, want 0");
        end else begin
          mon_e = sb_q.pop_front();
          check("rsp_data", rsp_data, mon_e.data);
          check("rsp_error", rsp_error, mon_e.err);
          check("frame_bits", cap_bits & mon_e.oe, mon_e.frame & mon_e.oe);
          check("frame_oe", cap_oe, mon_e.oe);
          check("mdc_rises", rise_cnt, 64);
          check("rsp_latency", cyc - mon_e.acc, LAT);
          last_data = mon_e.data;
          last_err  = mon_e.err;
        end
        last_rsp_cyc = cyc;
        rise_cnt = 0;
        mdio_i = 1'b1;
      end else if (rsp_data !== last_data || rsp_error !== last_err) begin
        hold_err++;
      end
    end
    mdc_prev     = mdc;
    mdio_o_prev  = mdio_o;
    mdio_oe_prev = mdio_oe;
  end

  // Present one command, wait for acceptance, and push its expected response.
  task automatic issue(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] d, input logic present, input logic [15:0] val,
                       input bit scramble, input bit hold, output longint acc);
    int   guard = 0;
    exp_t e;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 2000) begin
      if (scramble) begin
        cmd_write    = 1'($urandom);
        cmd_phy_addr = 5'($urandom);
        cmd_reg_addr = 5'($urandom);
        cmd_data     = 16'($urandom);
      end
      @(posedge clk_i); #1;
      guard++;
    end
    acc = 0;
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got cmd_ready=0 for %0d cycles, want 1", guard);
      cmd_valid = 1'b0;
      return;
    end
    cmd_write    = w;
    cmd_phy_addr = pa;
    cmd_reg_addr = ra;
    cmd_data     = d;
    e     = model(w, pa, ra, d, present, val);
    e.acc = cyc + 1;
    acc   = e.acc;
    sb_q.push_back(e);
    @(posedge clk_i); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 1000) begin
      @(posedge clk_i); #1;
      guard++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    longint acc1;
    longint acc2;
    int     toggles;
    int     guard;
    logic   m0;

    // Reset values while held in reset.
    repeat (5) @(posedge clk_i);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_mdc", mdc, 0);
    check("rst_mdio_o", mdio_o, 1);
    check("rst_mdio_oe", mdio_oe, 0);

    // Release: ready on the first cycle, bus idle, MDC static.
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    check("rel_cmd_ready", cmd_ready, 1);
    check("rel_busy", busy, 0);
    check("rel_mdc", mdc, 0);
    check("rel_mdio_oe", mdio_oe, 0);
    check("rel_mdio_o", mdio_o, 1);
    toggles = 0;
    m0 = mdc;
    repeat (1000) begin
      @(posedge clk_i); #1;
      if (mdc !== m0) toggles++;
    end
    check("mdc_static_idle", toggles, 0);

    // Directed write, read with PHY, read with no PHY.
    issue(1'b1, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0000, 1'b0, 1'b0, acc1);
    drain();
    issue(1'b0, 5'h00, 5'h02, 16'h0000, 1'b1, 16'h001C, 1'b0, 1'b0, acc1);
    drain();
    issue(1'b0, 5'h00, 5'h02, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, acc1);
    drain();

    // cmd_valid held with fields changing during a write frame.
    issue(1'b1, 5'h15, 5'h0A, 16'hA5C3, 1'b0, 16'h0000, 1'b0, 1'b1, acc1);
    issue(1'b0, 5'h03, 5'h11, 16'h0000, 1'b1, 16'hBEEF, 1'b1, 1'b0, acc2);
    check("b2b_accept_gap", acc2 - last_rsp_cyc, 2);
    drain();

    // Random commands.
    repeat (12) begin
      issue(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
            ($urandom_range(0, 3) != 0), 16'($urandom), 1'b0, 1'b0, acc1);
      drain();
    end

    // Reset in the middle of bit 40.
    issue(1'b0, 5'h07, 5'h1F, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0, acc1);
    guard = 0;
    while (rise_cnt < 40 && guard < 1000) begin
      @(posedge clk_i); #1;
      guard++;
    end
    check("reached_bit40", rise_cnt, 40);
    rst_n_i = 1'b0;
    @(posedge clk_i); #1;
    sb_q.delete();
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp_data", rsp_data, 0);
    check("mid_rst_mdc", mdc, 0);
    check("mid_rst_mdio_o", mdio_o, 1);
    check("mid_rst_mdio_oe", mdio_oe, 0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    check("mid_rel_cmd_ready", cmd_ready, 1);
    repeat (300) @(posedge clk_i);
    #1;
    issue(1'b1, 5'h1E, 5'h05, 16'h8001, 1'b0, 16'h0000, 1'b0, 1'b0, acc1);
    drain();
    issue(1'b0, 5'h01, 5'h01, 16'h0000, 1'b1, 16'h796D, 1'b0, 1'b0, acc1);
    drain();

    check("mdc_timing_errors", timing_err, 0);
    check("mdio_change_errors", change_err, 0);
    check("rsp_hold_errors", hold_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
